// File: rtl/core_pwr_seq.sv
// -----------------------------------------------------------------------------
// core_pwr_seq
//   Clock-enable / reset sequencer for one clock/reset domain (E core, P core
//   or SYS link). It sits behind the system-control register block and turns
//   the software request bits plus PLL lock into an ordered bring-up and
//   tear-down:
//     up  : PLL locked -> clock enabled -> settle time -> reset released
//     down: reset asserted -> hold time -> clock gated
//
//   Optional feature macro: CORE_PWR_SEQ_LOCK_TIMEOUT_EN
//     defined   : WAIT_LOCK times out after LOCK_TIMEOUT_CYCLES into FAULT
//                 (err_o=1); FAULT is left only by dropping clk_en_req_i.
//     undefined : WAIT_LOCK waits forever, FAULT unreachable, err_o tied 0.
//
//   Ports
//     clk_i          in   system clock
//     arst_ni        in   asynchronous active-low reset
//     clk_en_req_i   in   requested clock enable (register bit 0)
//     rst_n_req_i    in   requested active-low reset (register bit 1)
//     pll_locked_i   in   PLL lock, asynchronous to clk_i
//     core_clk_en_o  out  clock-gate enable to the domain
//     core_rst_no    out  active-low reset to the domain
//     busy_o         out  sequence in progress
//     state_o  [2:0] out  current state encoding for status readback
//     err_o          out  lock-timeout fault
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   OFF      0 | clock gated, reset asserted, idle
//   WAIT_LOCK 1| request seen, waiting for synchronized PLL lock
//   CLK_ON   2 | clock running, reset held for the settle time
//   RUN      3 | clock running, reset released
//   RST_HOLD 4 | reset asserted, clock kept running for the hold time
//   FAULT    5 | PLL lock timed out (feature build only)
// -----------------------------------------------------------------------------
module core_pwr_seq #(
  parameter int unsigned CLK_SETTLE_CYCLES   = 16,
  parameter int unsigned RST_HOLD_CYCLES     = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       clk_en_req_i,
  input  logic       rst_n_req_i,
  input  logic       pll_locked_i,
  output logic       core_clk_en_o,
  output logic       core_rst_no,
  output logic       busy_o,
  output logic [2:0] state_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CLK_ON    = 3'd2,
    ST_RUN       = 3'd3,
    ST_RST_HOLD  = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam longint unsigned LP_CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

  // Catch a counter too narrow for the requested counts at elaboration.
  if (CLK_SETTLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      longint'(CLK_SETTLE_CYCLES) - 1 > LP_CNT_MAX ||
      longint'(RST_HOLD_CYCLES) - 1 > LP_CNT_MAX ||
      longint'(LOCK_TIMEOUT_CYCLES) - 1 > LP_CNT_MAX) begin : g_bad_params
    $error("core_pwr_seq: counts must be >=1 and fit in CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LP_SETTLE_LD = CNT_WIDTH'(CLK_SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_HOLD_LD   = CNT_WIDTH'(RST_HOLD_CYCLES - 1);

  logic                 r_lock_meta;
  logic                 r_lock_s;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_clk_en;
  logic                 r_rst_n;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_dec;
  logic [CNT_WIDTH-1:0] w_cnt_wait_ld;
  logic                 w_clk_en_nxt;
  logic                 w_rst_n_nxt;
  logic                 w_busy_nxt;

  // PLL lock crosses in from an unrelated clock.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_cnt_dec = (r_cnt != '0) ? r_cnt - 1'b1 : '0;

`ifdef CORE_PWR_SEQ_LOCK_TIMEOUT_EN
  assign w_cnt_wait_ld = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
`else
  // No timeout: the counter is left untouched while waiting for lock.
  assign w_cnt_wait_ld = r_cnt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (clk_en_req_i) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = w_cnt_wait_ld;
        end
      end
      ST_WAIT_LOCK: begin
        if (!clk_en_req_i) begin
          w_state_nxt = ST_OFF;
        end else if (r_lock_s) begin
          w_state_nxt = ST_CLK_ON;
          w_cnt_nxt   = LP_SETTLE_LD;
        end
`ifdef CORE_PWR_SEQ_LOCK_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
`endif
      end
      ST_CLK_ON: begin
        // Request drop wins over lock loss so the domain gets its hold time.
        if (!clk_en_req_i) begin
          w_state_nxt = ST_RST_HOLD;
          w_cnt_nxt   = LP_HOLD_LD;
        end else if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = w_cnt_wait_ld;
        end else if (r_cnt == '0 && rst_n_req_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = w_cnt_wait_ld;
        end else if (!clk_en_req_i || !rst_n_req_i) begin
          w_state_nxt = ST_RST_HOLD;
          w_cnt_nxt   = LP_HOLD_LD;
        end
      end
      ST_RST_HOLD: begin
        // Requests are only looked at once the hold time has fully elapsed.
        if (r_cnt != '0) begin
          w_cnt_nxt = w_cnt_dec;
        end else if (!clk_en_req_i) begin
          w_state_nxt = ST_OFF;
        end else if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = w_cnt_wait_ld;
        end else begin
          w_state_nxt = ST_CLK_ON;
          w_cnt_nxt   = LP_SETTLE_LD;
        end
      end
      ST_FAULT: begin
        if (!clk_en_req_i) begin
          w_state_nxt = ST_OFF;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they flip on the same edge as state_o.
  always_comb begin
    w_clk_en_nxt = 1'b0;
    w_rst_n_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    case (w_state_nxt)
      ST_WAIT_LOCK: w_busy_nxt = 1'b1;
      ST_CLK_ON: begin
        w_clk_en_nxt = 1'b1;
        w_busy_nxt   = (w_cnt_nxt != '0);
      end
      ST_RUN: begin
        w_clk_en_nxt = 1'b1;
        w_rst_n_nxt  = 1'b1;
      end
      ST_RST_HOLD: begin
        w_clk_en_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_rst_n  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

`ifdef CORE_PWR_SEQ_LOCK_TIMEOUT_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == ST_FAULT);
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign core_clk_en_o = r_clk_en;
  assign core_rst_no   = r_rst_n;
  assign busy_o        = r_busy;
  assign state_o       = r_state;

endmodule
